// File: rtl/pixie_pkg.sv
// rtl/pixie_pkg.sv - shared constants and types for the pixie display DMA front end
package pixie_pkg;

  // CPU state codes presented on sc
  localparam logic [1:0] SC_FETCH   = 2'b00;
  localparam logic [1:0] SC_EXECUTE = 2'b01;
  localparam logic [1:0] SC_DMA     = 2'b10;
  localparam logic [1:0] SC_INT     = 2'b11;

  // Vertical line-repeat encoding
  typedef enum logic [1:0] {
    REP_1X = 2'd0,
    REP_2X = 2'd1,
    REP_4X = 2'd2,
    REP_8X = 2'd3
  } line_repeat_t;

  // Classic 1861 geometry
  localparam int unsigned DEF_BYTES_PER_LINE    = 14;
  localparam int unsigned DEF_LINES_PER_FRAME   = 262;
  localparam int unsigned DEF_ACTIVE_FIRST_LINE = 80;
  localparam int unsigned DEF_ACTIVE_LINES      = 128;

  // Last value of the repeat counter for a given scaling mode
  function automatic logic [2:0] rep_last(input line_repeat_t mode);
    case (mode)
      REP_1X:  return 3'd0;
      REP_2X:  return 3'd1;
      REP_4X:  return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/pixie_timing_gen.sv
// rtl/pixie_timing_gen.sv - scan counters, frame pulse and line-scoped display flags
module pixie_timing_gen
  import pixie_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE    = DEF_BYTES_PER_LINE,
  parameter int unsigned LINES_PER_FRAME   = DEF_LINES_PER_FRAME,
  parameter int unsigned DMA_FIRST_COL     = 1,
  parameter int unsigned DMA_LAST_COL      = 8,
  parameter int unsigned ACTIVE_FIRST_LINE = DEF_ACTIVE_FIRST_LINE,
  parameter int unsigned ACTIVE_LINES      = DEF_ACTIVE_LINES,
  parameter int unsigned INT_LEAD          = 2,
  parameter int unsigned EFX_LEAD          = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_enable,
  input  logic enabled_next,
  output logic h_wrap,
  output logic frame_wrap,
  output logic active,
  output logic int_flag,
  output logic efx,
  output logic dmao,
  output logic frame_start
);

  localparam int unsigned H_W = $clog2(BYTES_PER_LINE);
  localparam int unsigned V_W = $clog2(LINES_PER_FRAME);
  localparam logic [H_W-1:0] H_LAST = H_W'(BYTES_PER_LINE - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(LINES_PER_FRAME - 1);
  localparam int unsigned ACT_END = ACTIVE_FIRST_LINE + ACTIVE_LINES;

  logic [H_W-1:0] h_cnt, h_next;
  logic [V_W-1:0] v_cnt, v_next;
  logic           active_d, int_d, efx_d, dmao_d;

  function automatic logic in_range(input logic [31:0] val, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

  assign h_wrap     = (h_cnt == H_LAST);
  assign frame_wrap = h_wrap && (v_cnt == V_LAST);

  // Next counter values and flags; line flags only re-evaluate on a line boundary,
  // but losing the enable drops active/INT straight away
  always_comb begin
    h_next   = h_wrap ? '0 : h_cnt + 1'b1;
    v_next   = v_cnt;
    active_d = active;
    int_d    = int_flag;
    efx_d    = efx;
    if (h_wrap) begin
      v_next   = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      active_d = enabled_next && in_range(32'(v_next), ACTIVE_FIRST_LINE, ACT_END);
      int_d    = enabled_next && in_range(32'(v_next), ACTIVE_FIRST_LINE - INT_LEAD,
                                          ACTIVE_FIRST_LINE);
      efx_d    = in_range(32'(v_next), ACTIVE_FIRST_LINE - EFX_LEAD, ACTIVE_FIRST_LINE) ||
                 in_range(32'(v_next), ACT_END - EFX_LEAD, ACT_END);
    end
    if (!enabled_next) begin
      active_d = 1'b0;
      int_d    = 1'b0;
    end
    dmao_d = enabled_next && active_d &&
             (32'(h_next) >= DMA_FIRST_COL) && (32'(h_next) <= DMA_LAST_COL);
  end

  // Counter and flag registers, advancing on machine-cycle strobes only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      active      <= 1'b0;
      int_flag    <= 1'b0;
      efx         <= 1'b0;
      dmao        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= clk_enable && frame_wrap;
      if (clk_enable) begin
        h_cnt    <= h_next;
        v_cnt    <= v_next;
        active   <= active_d;
        int_flag <= int_d;
        efx      <= efx_d;
        dmao     <= dmao_d;
      end
    end
  end

endmodule

// File: rtl/pixie_dma_front_end_gen.sv
// rtl/pixie_dma_front_end_gen.sv - display DMA front end: timing, S2 capture, frame buffer writes
module pixie_dma_front_end_gen
  import pixie_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE    = DEF_BYTES_PER_LINE,
  parameter int unsigned LINES_PER_FRAME   = DEF_LINES_PER_FRAME,
  parameter int unsigned DMA_FIRST_COL     = 1,
  parameter int unsigned DMA_LAST_COL      = 8,
  parameter int unsigned ACTIVE_FIRST_LINE = DEF_ACTIVE_FIRST_LINE,
  parameter int unsigned ACTIVE_LINES      = DEF_ACTIVE_LINES,
  parameter int unsigned INT_LEAD          = 2,
  parameter int unsigned EFX_LEAD          = 4,
  parameter int unsigned ADDR_W            = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic [1:0]        sc,
  input  logic              disp_on,
  input  logic              disp_off,
  input  logic [1:0]        line_repeat,
  input  logic [7:0]        data,
  output logic              dmao,
  output logic              INT,
  output logic              efx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wr_en,
  output logic              frame_start,
  output logic              dma_err
);

  localparam int unsigned NBYTES = DMA_LAST_COL - DMA_FIRST_COL + 1;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] NBYTES_C = CNT_W'(NBYTES);

  logic              enabled, enabled_next;
  logic              h_wrap, frame_wrap, active;
  logic              qualify, line_end, active_line_end, rep_term;
  logic [ADDR_W-1:0] ptr, ptr_after, row_base, cap_addr;
  logic [CNT_W-1:0]  line_cnt, line_cnt_after;
  logic [2:0]        rep_cnt;
  line_repeat_t      rep_mode;
  logic [7:0]        cap_data;
  logic              cap_valid;

  pixie_timing_gen #(
    .BYTES_PER_LINE   (BYTES_PER_LINE),
    .LINES_PER_FRAME  (LINES_PER_FRAME),
    .DMA_FIRST_COL    (DMA_FIRST_COL),
    .DMA_LAST_COL     (DMA_LAST_COL),
    .ACTIVE_FIRST_LINE(ACTIVE_FIRST_LINE),
    .ACTIVE_LINES     (ACTIVE_LINES),
    .INT_LEAD         (INT_LEAD),
    .EFX_LEAD         (EFX_LEAD)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .enabled_next(enabled_next),
    .h_wrap      (h_wrap),
    .frame_wrap  (frame_wrap),
    .active      (active),
    .int_flag    (INT),
    .efx         (efx),
    .dmao        (dmao),
    .frame_start (frame_start)
  );

  // Display enable after this strobe: disp_on wins over disp_off
  always_comb begin
    enabled_next = enabled;
    if (clk_enable) begin
      if (disp_on) begin
        enabled_next = 1'b1;
      end else if (disp_off) begin
        enabled_next = 1'b0;
      end
    end
  end

  // A DMA byte is accepted only while the line still has room for it
  always_comb begin
    qualify         = clk_enable && (sc == SC_DMA) && enabled && active && (line_cnt < NBYTES_C);
    ptr_after       = ptr + ADDR_W'(qualify);
    line_cnt_after  = line_cnt + CNT_W'(qualify);
    line_end        = clk_enable && h_wrap;
    active_line_end = line_end && active;
    rep_term        = (rep_cnt == rep_last(rep_mode));
  end

  // Enable register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enabled <= 1'b0;
    end else begin
      enabled <= enabled_next;
    end
  end

  // Capture stage plus pointer, row rewind and repeat bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_valid <= 1'b0;
      cap_addr  <= '0;
      cap_data  <= '0;
      ptr       <= '0;
      row_base  <= '0;
      line_cnt  <= '0;
      rep_cnt   <= '0;
      rep_mode  <= REP_1X;
    end else begin
      cap_valid <= qualify;
      if (qualify) begin
        cap_addr <= ptr;
        cap_data <= data;
      end
      if (clk_enable) begin
        ptr      <= ptr_after;
        line_cnt <= line_cnt_after;
        if (active_line_end) begin
          if (!rep_term) begin
            ptr <= row_base;
          end else begin
            row_base <= ptr_after;
          end
          rep_cnt <= rep_term ? 3'd0 : rep_cnt + 3'd1;
        end
        if (line_end) begin
          line_cnt <= '0;
        end
        // The captured byte already holds its old address, so clearing here is safe
        if (frame_wrap) begin
          ptr      <= '0;
          row_base <= '0;
          rep_cnt  <= '0;
          line_cnt <= '0;
          rep_mode <= line_repeat_t'(line_repeat);
        end
      end
    end
  end

  // Sticky underrun: a short active line sets it, disp_on clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_err <= 1'b0;
    end else if (clk_enable) begin
      if (active_line_end && (line_cnt_after < NBYTES_C)) begin
        dma_err <= 1'b1;
      end else if (disp_on) begin
        dma_err <= 1'b0;
      end
    end
  end

  // Frame buffer write port, one clk behind the capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      mem_wr_en <= cap_valid;
      if (cap_valid) begin
        mem_addr <= cap_addr;
        mem_data <= cap_data;
      end
    end
  end

endmodule

// File: tb/tb_pixie_dma_front_end_gen.sv
// tb/tb_pixie_dma_front_end_gen.sv - scoreboard bench for pixie_dma_front_end_gen
module tb_pixie_dma_front_end_gen;

  localparam int BPL = 14;
  localparam int LPF = 262;
  localparam int AFL = 80;
  localparam int AL  = 128;
  localparam int NB  = 8;

  localparam int POL_NONE   = 0;
  localparam int POL_RANDOM = 1;
  localparam int POL_WINDOW = 2;
  localparam int POL_BURST  = 3;
  localparam int POL_ALWAYS = 4;

  logic       clk = 1'b0;
  logic       reset, clk_enable, disp_on, disp_off;
  logic [1:0] sc, line_repeat;
  logic [7:0] data;
  logic       dmao, int_req, efx, mem_wr_en, frame_start, dma_err;
  logic [9:0] mem_addr;
  logic [7:0] mem_data;

  typedef struct {
    int a;
    int d;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int max_addr = 0;
  int policy = POL_NONE;
  int burst_n = 0;
  bit last_ce = 0;

  // reference model state
  int m_h, m_v, m_ptr, m_row, m_rep, m_mode, m_cnt;
  bit m_en, m_act, m_int, m_efx, m_dmao, m_fs, m_err;

  always #5 clk = ~clk;

  pixie_dma_front_end_gen dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .sc         (sc),
    .disp_on    (disp_on),
    .disp_off   (disp_off),
    .line_repeat(line_repeat),
    .data       (data),
    .dmao       (dmao),
    .INT        (int_req),
    .efx        (efx),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wr_en  (mem_wr_en),
    .frame_start(frame_start),
    .dma_err    (dma_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (v=%0d h=%0d)", name, act, exp, m_v, m_h);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_ptr = 0; m_row = 0; m_rep = 0; m_mode = 0; m_cnt = 0;
    m_en = 0; m_act = 0; m_int = 0; m_efx = 0; m_dmao = 0; m_fs = 0; m_err = 0;
    exp_q.delete();
  endtask

  function automatic bit in_rng(input int val, input int lo, input int hi);
    return (val >= lo) && (val < hi);
  endfunction

  // one machine cycle of the display, following the frame/line rules directly
  task automatic model_tick();
    exp_t e;
    if ((sc == 2'b10) && m_en && m_act && (m_cnt < NB)) begin
      e.a = m_ptr;
      e.d = int'(data);
      exp_q.push_back(e);
      m_ptr = (m_ptr + 1) % 1024;
      m_cnt++;
    end
    if (disp_on) begin
      m_en = 1; m_err = 0;
    end else if (disp_off) begin
      m_en = 0;
    end
    if (m_h == BPL - 1) begin
      if (m_act) begin
        if (m_cnt < NB) m_err = 1;
        if (m_rep != (1 << m_mode) - 1) m_ptr = m_row;
        else m_row = m_ptr;
        m_rep = (m_rep + 1) % (1 << m_mode);
      end
      m_cnt = 0;
      m_h = 0;
      m_v = (m_v + 1) % LPF;
      if (m_v == 0) begin
        m_fs = 1; m_ptr = 0; m_row = 0; m_rep = 0; m_mode = int'(line_repeat);
      end
      m_act = m_en && in_rng(m_v, AFL, AFL + AL);
      m_int = m_en && in_rng(m_v, AFL - 2, AFL);
      m_efx = in_rng(m_v, AFL - 4, AFL) || in_rng(m_v, AFL + AL - 4, AFL + AL);
    end else begin
      m_h++;
    end
    if (!m_en) begin
      m_act = 0; m_int = 0;
    end
    m_dmao = m_en && m_act && (m_h >= 1) && (m_h <= NB);
  endtask

  task automatic step(input bit force_ce, input bit don, input bit doff);
    @(negedge clk);
    last_ce = force_ce || ($urandom_range(3) != 0);
    data = 8'($urandom);
    case (policy)
      POL_NONE:   sc = 2'b00;
      POL_RANDOM: sc = 2'($urandom);
      POL_WINDOW: sc = m_dmao ? 2'b10 : 2'($urandom_range(1));
      POL_BURST:  sc = (m_h < burst_n) ? 2'b10 : 2'b00;
      default:    sc = 2'b10;
    endcase
    clk_enable = last_ce;
    disp_on = don;
    disp_off = doff;
    m_fs = 0;
    if (last_ce) model_tick();
    @(posedge clk);
    #1;
    check("dmao", dmao, m_dmao);
    check("INT", int_req, m_int);
    check("efx", efx, m_efx);
    check("dma_err", dma_err, m_err);
    check("frame_start", frame_start, m_fs);
    disp_on = 0;
    disp_off = 0;
  endtask

  task automatic run_until(input int v, input int h);
    int guard = 0;
    bit moved = 0;
    do begin
      step(0, 0, 0);
      moved = moved | last_ce;
      guard++;
    end while (!(moved && m_v == v && m_h == h) && guard < 20000);
    if (guard >= 20000) check("run_until_reached", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dmao"}, dmao, 0);
    check({tag, "_INT"}, int_req, 0);
    check({tag, "_efx"}, efx, 0);
    check({tag, "_mem_wr_en"}, mem_wr_en, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_data"}, mem_data, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_dma_err"}, dma_err, 0);
  endtask

  // write monitor: every frame buffer write must match the oldest expected one
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mem_wr_en === 1'b1) begin
      wr_count++;
      if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual_addr=%0d required=no write", mem_addr);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.a);
        check("wr_data", mem_data, e.d);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int w0;
    int n;
    bit found;
    reset = 1; clk_enable = 0; sc = 0; data = 0;
    disp_on = 0; disp_off = 0; line_repeat = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) reset = 0;

    // display off for a frame: efx toggles, INT stays low, no writes
    policy = POL_RANDOM;
    run_until(LPF - 1, 0);
    step(1, 1, 0);
    run_until(0, 0);

    // full DMA frame at 1x
    policy = POL_WINDOW;
    w0 = wr_count; max_addr = 0;
    step(0, 0, 0);
    line_repeat = 2'd2;
    run_until(0, 0);
    check("frame_1x_writes", wr_count - w0, 1024);
    check("frame_1x_max_addr", max_addr, 1023);

    // full DMA frame at 4x
    w0 = wr_count; max_addr = 0;
    step(0, 0, 0);
    line_repeat = 2'd0;
    run_until(0, 0);
    check("frame_4x_writes", wr_count - w0, 1024);
    check("frame_4x_max_addr", max_addr, 255);

    // per-line capping and underrun
    run_until(100, 0);
    policy = POL_BURST; burst_n = 10;
    w0 = wr_count;
    run_until(100, 12);
    check("burst10_writes", wr_count - w0, 8);
    run_until(101, 0);
    burst_n = 7;
    w0 = wr_count;
    run_until(101, 12);
    check("burst7_writes", wr_count - w0, 7);
    run_until(102, 0);
    check("underrun_flag", dma_err, 1);
    policy = POL_WINDOW;
    step(1, 1, 0);
    check("underrun_cleared", dma_err, 0);

    // disp_off mid-line, then disp_on mid-line
    run_until(100, 4);
    step(1, 0, 1);
    check("dmao_off_next", dmao, 0);
    policy = POL_RANDOM;
    step(0, 0, 0);
    step(0, 0, 0);
    w0 = wr_count;
    run_until(120, 5);
    check("writes_while_off", wr_count - w0, 0);
    policy = POL_WINDOW;
    step(1, 1, 0);
    run_until(121, 1);
    check("dmao_resume", dmao, 1);

    // reset with a write pending
    policy = POL_NONE;
    run_until(130, 0);
    run_until(130, 4);
    policy = POL_ALWAYS;
    step(1, 0, 0);
    #1 reset = 1;
    clk_enable = 0; sc = 0;
    #1;
    check_all_zero("midreset");
    model_reset();
    w0 = wr_count;
    repeat (3) @(negedge clk);
    check("write_after_reset", wr_count - w0, 0);
    reset = 0;

    // counters restart from zero: first frame_start after a full frame of strobes
    policy = POL_RANDOM;
    n = 0; found = 0;
    for (int i = 0; i < 6000 && !found; i++) begin
      step(0, 0, 0);
      if (last_ce) n++;
      if (frame_start === 1'b1) found = 1;
    end
    check("frame_period", n, BPL * LPF);

    repeat (4) step(0, 0, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixie_dma_front_end_gen.md
Name: pixie_dma_front_end_gen

Overview:
Parametrised successor to the CDP1861-style display DMA front end. Generates the video frame timing (horizontal and vertical counters), DMAOUT requests, INT and EFX, and captures the bytes the CPU supplies during S2 (DMA) cycles into a frame buffer write port. New relative to the fixed 1861 front end:
- geometry set by parameters;
- runtime line-repeat mode (1x/2x/4x/8x vertical scaling with buffer rewind);
- per-line DMA byte capping;
- sticky DMA-underrun flag;
- frame-start pulse.
Sits between the CPU core (sc/data bus) and the video frame-buffer RAM.

Parameters:
BYTES_PER_LINE, 14, machine cycles per scanline (h counter modulus)
LINES_PER_FRAME, 262, scanlines per frame (v counter modulus)
DMA_FIRST_COL, 1, first h count with dmao asserted
DMA_LAST_COL, 8, last h count with dmao asserted (8 bytes/line default)
ACTIVE_FIRST_LINE, 80, first active scanline
ACTIVE_LINES, 128, number of active scanlines
INT_LEAD, 2, INT lines before ACTIVE_FIRST_LINE
EFX_LEAD, 4, EFX lines before active start and before active end
ADDR_W, 10, frame buffer address width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
clk_enable  in  1  one-cycle machine-cycle strobe; all state advances only on it
sc  in  2  CPU state code (2'b10 = DMA cycle)
disp_on  in  1  display enable strobe
disp_off  in  1  display disable strobe
line_repeat  in  2  vertical repeat: 0=1x, 1=2x, 2=4x, 3=8x
data  in  8  CPU data bus
dmao  out  1  DMA-out request
INT  out  1  interrupt request
efx  out  1  EF1 flag
mem_addr  out  ADDR_W  frame buffer write address
mem_data  out  8  frame buffer write data
mem_wr_en  out  1  frame buffer write strobe, one clk wide
frame_start  out  1  one-clk pulse at frame wrap
dma_err  out  1  sticky DMA underrun flag

Behaviour:
- Reset (async, active-high): every register and output is 0, including the counters, enabled, the pointer and dma_err.
- Enable:
  - on clk_enable, priority is disp_on > disp_off.
  - disp_on also clears dma_err.
- Counters:
  - h counts 0..BYTES_PER_LINE-1; v counts 0..LINES_PER_FRAME-1.
  - v advances when h wraps; v wraps to 0 after LINES_PER_FRAME-1.
  - frame_start pulses for one clk on the clk_enable where both counters wrap.
- Line-scoped flags, latched at each h wrap from the new v value:
  - active = enabled && v in [ACTIVE_FIRST_LINE, ACTIVE_FIRST_LINE+ACTIVE_LINES).
  - INT = enabled && v in [ACTIVE_FIRST_LINE-INT_LEAD, ACTIVE_FIRST_LINE).
  - efx = v in [AFL-EFX_LEAD, AFL) or [AFL+AL-EFX_LEAD, AFL+AL), independent of enabled.
  - Enabling mid-line takes effect at the next line boundary.
- dmao: registered, = enabled && active && h in [DMA_FIRST_COL, DMA_LAST_COL].
  - disp_off deasserts dmao and INT on the next clk_enable.
- DMA capture:
  - Qualifying cycle = clk_enable && sc==2'b10 && enabled && active && line_cnt < NBYTES, where NBYTES = DMA_LAST_COL-DMA_FIRST_COL+1.
  - On a qualifying cycle: latch data and ptr.
  - One clk later: mem_wr_en=1 with mem_addr = latched ptr and mem_data = latched data. Latency is 1 clk.
  - After the write, ptr increments modulo 2^ADDR_W and line_cnt increments.
  - Extra S2 cycles beyond NBYTES in a line are dropped: no write, no pointer change.
- Line repeat (line_repeat sampled at frame wrap only, held for the frame):
  - rep_cnt counts 0..(2^line_repeat)-1 across active lines.
  - At the end of an active line: if rep_cnt is not terminal, ptr rewinds to row_base; otherwise row_base ← ptr. rep_cnt advances in both cases.
  - Result: unique rows stored = ACTIVE_LINES >> line_repeat; repeated lines overwrite the same addresses.
- Underrun: at the end of each active line, line_cnt < NBYTES sets dma_err (sticky). line_cnt then clears.
- Frame wrap: ptr, row_base, rep_cnt and line_cnt all clear.
- Simultaneous frame wrap and final capture: the write for the last byte completes to the old address first; then ptr clears.
- Reset mid-line: immediate clear; any pending write is discarded.

Decomposition:
- Shared package pixie_pkg holds:
  - SC_FETCH/SC_EXECUTE/SC_DMA/SC_INT state-code constants;
  - the line_repeat encoding constants;
  - default 1861 geometry constants (14, 262, 80, 128).
- One natural sub-module: pixie_timing_gen (h/v counters, frame_start, line-scoped flags). Capture, pointer and repeat logic stay in the top level.

Test Plan:
- Defaults, disp_on, sc=2'b10 on every dmao window for one frame -> dmao high on h=1..8 of v=80..207; 1024 writes to addresses 0..1023; dma_err=0; frame_start every 14*262 enables.
- Defaults with INT/EFX observation -> INT high on v=78,79 only; efx high on v=76..79 and 204..207; with enabled=0, efx still toggles and INT stays 0.
- line_repeat=2 (4x), full DMA -> addresses span 0..255 only, each row written 4 times; the 4th write to row 0 is still address 0..7.
- Supply 10 S2 cycles in one active line -> exactly 8 writes; ptr advances 8. Supply 7 -> 7 writes; dma_err=1 after the line; cleared by next disp_on.
- disp_off at v=100,h=4 -> dmao low the next enable; no further writes; ptr held. disp_on mid-line -> dmao resumes only from the next line.
- Assert reset at h=5 of an active line while a write is pending -> mem_wr_en never pulses; all outputs 0 immediately; the counters restart at 0.
